// File: rtl/rv32_memory.sv
// rv32_memory: RV32 memory stage with a req/gnt/rvalid data-memory port.
//
// Optional feature: define RV32_MEM_MISALIGN_EXC_EN to enable the misaligned-access
// flag (misaligned_o). When it is undefined, half accesses use a[1] only, word
// accesses ignore a[1:0], and no access is ever blocked.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   reg_write_i .. write_data_i  execute-to-memory control and data (alu_result_i = address)
//   dmem_req_o/we/addr/be/wdata  data-memory request (held until dmem_gnt_i)
//   dmem_gnt_i/rvalid_i/rdata_i  data-memory grant and read response
//   stall_o                   combinational freeze request to the hazard unit
//   misaligned_o              combinational misaligned-access flag (macro only)
//   reg_write_o .. read_data_o   memory-to-writeback register
module rv32_memory (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        reg_write_i,
    input  logic        memory_write_i,
    input  logic [1:0]  result_source_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_next_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] write_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
`ifdef RV32_MEM_MISALIGN_EXC_EN
    output logic        misaligned_o,
`endif
    output logic        reg_write_o,
    output logic [1:0]  result_source_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_next_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] read_data_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BEW  = XLEN / 8;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      funct3;
    logic [1:0]      offset;
    logic            access;
    logic            load;
    logic            store;
    logic            misaligned;
    logic            issue;
    logic            in_idle;
    logic            in_wait;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic [BEW-1:0]  be;
    logic [XLEN-1:0] wdata;

    // Access decode
    always_comb begin
        funct3  = instr_i[14:12];
        offset  = alu_result_i[1:0];
        access  = memory_write_i | (result_source_i == 2'b01);
        load    = access & ~memory_write_i;
        store   = memory_write_i;
        in_idle = (state == IDLE);
        in_wait = (state == WAIT_RSP);
    end

`ifdef RV32_MEM_MISALIGN_EXC_EN
    // Half accesses need a[0]=0, word accesses need a[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        if (access) begin
            case (funct3[1:0])
                2'b01:   misaligned = offset[0];
                2'b10:   misaligned = |offset;
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign misaligned_o = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned access is dropped: no request, no stall
    assign issue = access & ~misaligned;

    // Request and stall are gated by reset so both read 0 while it is asserted
    always_comb begin
        dmem_req_o = rst_n_i & in_idle & issue;
        stall_o    = rst_n_i & ((in_idle & issue & ~(store & dmem_gnt_i))
                              | (in_wait & ~dmem_rvalid_i));
    end

    assign dmem_addr_o  = {alu_result_i[31:2], 2'b00};
    assign dmem_we_o    = memory_write_i;
    assign dmem_be_o    = be;
    assign dmem_wdata_o = wdata;

    // Store lane steering; loads always fetch the full word
    always_comb begin
        be    = '0;
        wdata = '0;
        if (issue) begin
            if (store) begin
                case (funct3)
                    3'b000: begin
                        be    = BEW'(4'b0001 << offset);
                        wdata = {4{write_data_i[7:0]}};
                    end
                    3'b001: begin
                        be    = BEW'(4'b0011 << {offset[1], 1'b0});
                        wdata = {2{write_data_i[15:0]}};
                    end
                    default: begin
                        be    = 4'b1111;
                        wdata = write_data_i;
                    end
                endcase
            end else begin
                be = 4'b1111;
            end
        end
    end

    // Load lane extraction and extension
    always_comb begin
        case (offset)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = offset[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem_rdata_i;
        endcase
    end

    // Access FSM; rvalid is only honoured in WAIT_RSP, so a stale response after reset is dropped
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (issue && load && dmem_gnt_i) state <= WAIT_RSP;
                WAIT_RSP: if (dmem_rvalid_i)               state <= IDLE;
                default:                                   state <= IDLE;
            endcase
        end
    end

    // Memory-to-writeback register; a stall inserts a bubble by clearing reg_write
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_write_o     <= 1'b0;
            result_source_o <= 2'b00;
            instr_o         <= '0;
            pc_next_o       <= '0;
            alu_result_o    <= '0;
            read_data_o     <= '0;
        end else if (stall_o) begin
            reg_write_o <= 1'b0;
        end else begin
            reg_write_o     <= reg_write_i & ~misaligned;
            result_source_o <= result_source_i;
            instr_o         <= instr_i;
            pc_next_o       <= pc_next_i;
            alu_result_o    <= alu_result_i;
            read_data_o     <= (in_wait && dmem_rvalid_i) ? ld_ext : '0;
        end
    end

endmodule

// File: tb/tb_rv32_memory.sv
// tb_rv32_memory: directed bench for rv32_memory; load results go through a
// scoreboard queue filled when the load is driven and drained at writeback.
module tb_rv32_memory;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        reg_write_i;
    logic        memory_write_i;
    logic [1:0]  result_source_i;
    logic [31:0] instr_i;
    logic [31:0] pc_next_i;
    logic [31:0] alu_result_i;
    logic [31:0] write_data_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
`ifdef RV32_MEM_MISALIGN_EXC_EN
    logic        misaligned_o;
`endif
    logic        reg_write_o;
    logic [1:0]  result_source_o;
    logic [31:0] instr_o;
    logic [31:0] pc_next_o;
    logic [31:0] alu_result_o;
    logic [31:0] read_data_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
    } wb_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    wb_t     sb_q[$];
    ld_vec_t ld_tab[6];

    always #5 clk_i = ~clk_i;

    rv32_memory dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .reg_write_i     (reg_write_i),
        .memory_write_i  (memory_write_i),
        .result_source_i (result_source_i),
        .instr_i         (instr_i),
        .pc_next_i       (pc_next_i),
        .alu_result_i    (alu_result_i),
        .write_data_i    (write_data_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_o         (stall_o),
`ifdef RV32_MEM_MISALIGN_EXC_EN
        .misaligned_o    (misaligned_o),
`endif
        .reg_write_o     (reg_write_o),
        .result_source_o (result_source_o),
        .instr_o         (instr_o),
        .pc_next_o       (pc_next_o),
        .alu_result_o    (alu_result_o),
        .read_data_o     (read_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        reg_write_i     = 1'b0;
        memory_write_i  = 1'b0;
        result_source_i = 2'b00;
        instr_i         = 32'h0;
        pc_next_i       = 32'h0;
        alu_result_i    = 32'h0;
        write_data_i    = 32'h0;
        dmem_gnt_i      = 1'b0;
        dmem_rvalid_i   = 1'b0;
        dmem_rdata_i    = 32'h0;
    endtask

    task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        reg_write_i     = 1'b0;
        memory_write_i  = 1'b1;
        result_source_i = 2'b00;
        instr_i         = {17'h0, f3, 5'd0, 7'h23};
        pc_next_i       = addr + 32'd4;
        alu_result_i    = addr;
        write_data_i    = data;
    endtask

    // Push the expected writeback before the load goes out
    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        wb_t e;
        reg_write_i     = 1'b1;
        memory_write_i  = 1'b0;
        result_source_i = 2'b01;
        instr_i         = {17'h0, f3, 5'd1, 7'h03};
        pc_next_i       = addr + 32'd4;
        alu_result_i    = addr;
        write_data_i    = 32'h0;
        e.rd   = exp;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_read_data"}, read_data_o, e.rd);
            chk({tag, "_alu_result"}, alu_result_o, e.addr);
            chk({tag, "_reg_write"}, 32'(reg_write_o), 32'd1);
        end
    endtask

    task automatic comb_point();
        @(negedge clk_i);
    endtask

    task automatic reg_point();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ld_tab[0] = '{3'b101, 32'h0000_0102, 32'hBEEF_1234, 32'h0000_BEEF};
        ld_tab[1] = '{3'b001, 32'h0000_0100, 32'h0000_8001, 32'hFFFF_8001};
        ld_tab[2] = '{3'b100, 32'h0000_0101, 32'h0000_F000, 32'h0000_00F0};
        ld_tab[3] = '{3'b010, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678};
        ld_tab[4] = '{3'b000, 32'h0000_0103, 32'h7F00_0000, 32'h0000_007F};
        ld_tab[5] = '{3'b001, 32'h0000_0102, 32'h8000_0000, 32'hFFFF_8000};

        // Reset state
        rst_n_i = 1'b0;
        drive_idle();
        reg_point();
        reg_point();
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_reg_write", 32'(reg_write_o), 32'd0);
        chk("rst_read_data", read_data_o, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        comb_point();
        rst_n_i = 1'b1;

        // SW 0x100, granted in the request cycle
        comb_point();
        drive_store(3'b010, 32'h100, 32'hDEAD_BEEF);
        dmem_gnt_i = 1'b1;
        #2;
        chk("sw_req", 32'(dmem_req_o), 32'd1);
        chk("sw_we", 32'(dmem_we_o), 32'd1);
        chk("sw_addr", dmem_addr_o, 32'h100);
        chk("sw_be", 32'(dmem_be_o), 32'hF);
        chk("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_stall", 32'(stall_o), 32'd0);
        reg_point();
        chk("sw_wb_alu", alu_result_o, 32'h100);
        chk("sw_wb_reg_write", 32'(reg_write_o), 32'd0);

        // SB 0x103
        comb_point();
        drive_store(3'b000, 32'h103, 32'h0000_00A5);
        #2;
        chk("sb_addr", dmem_addr_o, 32'h100);
        chk("sb_be", 32'(dmem_be_o), 32'h8);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_stall", 32'(stall_o), 32'd0);

        // SH 0x102
        comb_point();
        drive_store(3'b001, 32'h102, 32'h0000_1234);
        #2;
        chk("sh_be", 32'(dmem_be_o), 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'h1234_1234);

        // LB 0x102: gnt in cycle 0, rvalid in cycle 3
        comb_point();
        drive_load(3'b000, 32'h102, 32'hFFFF_FF80);
        dmem_gnt_i = 1'b1;
        #2;
        chk("lb_req", 32'(dmem_req_o), 32'd1);
        chk("lb_we", 32'(dmem_we_o), 32'd0);
        chk("lb_be", 32'(dmem_be_o), 32'hF);
        chk("lb_addr", dmem_addr_o, 32'h100);
        chk("lb_stall_c0", 32'(stall_o), 32'd1);
        reg_point();
        chk("lb_bubble_c0", 32'(reg_write_o), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            comb_point();
            dmem_gnt_i = 1'b0;
            #2;
            chk("lb_req_wait", 32'(dmem_req_o), 32'd0);
            chk("lb_stall_wait", 32'(stall_o), 32'd1);
            reg_point();
            chk("lb_bubble_wait", 32'(reg_write_o), 32'd0);
        end
        comb_point();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0080_0000;
        #2;
        chk("lb_stall_c3", 32'(stall_o), 32'd0);
        reg_point();
        check_wb("lb");

        // Load table: grant in cycle 0, rvalid in cycle 1
        foreach (ld_tab[i]) begin
            comb_point();
            drive_load(ld_tab[i].f3, ld_tab[i].addr, ld_tab[i].exp);
            dmem_gnt_i    = 1'b1;
            dmem_rvalid_i = 1'b0;
            #2;
            chk("ld_req", 32'(dmem_req_o), 32'd1);
            chk("ld_stall_c0", 32'(stall_o), 32'd1);
            reg_point();
            comb_point();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = ld_tab[i].rdata;
            #2;
            chk("ld_stall_c1", 32'(stall_o), 32'd0);
            reg_point();
            check_wb("ld_tab");
        end

        // LW 0x208 with grant withheld for two cycles
        comb_point();
        drive_load(3'b010, 32'h208, 32'hCAFE_F00D);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("nogrant_req", 32'(dmem_req_o), 32'd1);
            chk("nogrant_addr", dmem_addr_o, 32'h208);
            chk("nogrant_stall", 32'(stall_o), 32'd1);
            reg_point();
            chk("nogrant_bubble", 32'(reg_write_o), 32'd0);
            comb_point();
        end
        dmem_gnt_i = 1'b1;
        #2;
        chk("grant_req", 32'(dmem_req_o), 32'd1);
        reg_point();
        comb_point();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        #2;
        chk("no_dup_req", 32'(dmem_req_o), 32'd0);
        chk("rsp_stall", 32'(stall_o), 32'd0);
        reg_point();
        check_wb("lw_gnt_late");

        // Reset while in WAIT_RSP, then a stale rvalid
        comb_point();
        drive_load(3'b010, 32'h300, 32'h0);
        void'(sb_q.pop_back());
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b0;
        reg_point();
        comb_point();
        dmem_gnt_i = 1'b0;
        #2;
        chk("wait_stall", 32'(stall_o), 32'd1);
        rst_n_i = 1'b0;
        drive_idle();
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_req", 32'(dmem_req_o), 32'd0);
        chk("midrst_alu", alu_result_o, 32'd0);
        reg_point();
        comb_point();
        rst_n_i       = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_DEAD;
        #2;
        chk("stale_stall", 32'(stall_o), 32'd0);
        chk("stale_req", 32'(dmem_req_o), 32'd0);
        reg_point();
        chk("stale_reg_write", 32'(reg_write_o), 32'd0);
        chk("stale_read_data", read_data_o, 32'd0);

        // A fresh load must issue, proving the FSM is in IDLE
        comb_point();
        drive_load(3'b010, 32'h400, 32'h0BAD_F00D);
        dmem_gnt_i = 1'b1;
        #2;
        chk("post_rst_req", 32'(dmem_req_o), 32'd1);
        reg_point();
        comb_point();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0BAD_F00D;
        reg_point();
        check_wb("post_rst");

        // LW at 0x102
        comb_point();
`ifdef RV32_MEM_MISALIGN_EXC_EN
        drive_load(3'b010, 32'h102, 32'h0);
        void'(sb_q.pop_back());
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b0;
        #2;
        chk("mis_flag", 32'(misaligned_o), 32'd1);
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_stall", 32'(stall_o), 32'd0);
        reg_point();
        chk("mis_reg_write", 32'(reg_write_o), 32'd0);
`else
        drive_load(3'b010, 32'h102, 32'h5566_7788);
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b0;
        #2;
        chk("unal_req", 32'(dmem_req_o), 32'd1);
        chk("unal_addr", dmem_addr_o, 32'h100);
        reg_point();
        comb_point();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5566_7788;
        reg_point();
        check_wb("unal_lw");
`endif

        comb_point();
        drive_idle();
        reg_point();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_memory.md
RV32_MEMORY -- requirements
Module: rv32_memory

Interface
REQ-001 SHALL have ports clk_i (in, 1, single clock) and rst_n_i (in, 1); reset is asynchronous and active-low.
REQ-002 SHALL take reg_write_i, memory_write_i (in, 1) and result_source_i (in, 2) from execute-to-memory; 00 selects ALU, 01 load data, 10 pc_next.
REQ-003 SHALL take instr_i, pc_next_i, alu_result_i and write_data_i (in, 32) from execute-to-memory; alu_result_i is the effective address.
REQ-004 SHALL drive dmem_req_o (out, 1), dmem_we_o (out, 1), dmem_addr_o (out, 32, word-aligned), dmem_be_o (out, 4) and dmem_wdata_o (out, 32).
REQ-005 SHALL take dmem_gnt_i (in, 1, request accepted), dmem_rvalid_i (in, 1, read data valid) and dmem_rdata_i (in, 32).
REQ-006 SHALL drive stall_o (out, 1) so the hazard unit freezes all upstream registers while it is high.
REQ-007 SHALL drive misaligned_o (out, 1), a misaligned-access flag, present only with RV32_MEM_MISALIGN_EXC_EN.
REQ-008 SHALL drive reg_write_o, result_source_o[1:0], instr_o, pc_next_o, alu_result_o and read_data_o[31:0] from the memory-to-writeback register.

Function
REQ-009 SHALL define access = memory_write_i | (result_source_i==01); load = access & ~memory_write_i; funct3 = instr_i[14:12].
REQ-010 SHALL implement FSM IDLE/WAIT_RSP: IDLE & access -> dmem_req_o=1; load & dmem_gnt_i -> WAIT_RSP; store & dmem_gnt_i -> stay IDLE.
REQ-011 SHALL hold dmem_req_o and all dmem_* outputs stable until dmem_gnt_i; a request is never withdrawn before grant.
REQ-012 SHALL, in WAIT_RSP, keep dmem_req_o=0, return to IDLE on dmem_rvalid_i, and ignore dmem_rvalid_i while in IDLE.
REQ-013 SHALL drive stall_o combinationally: high when (IDLE & access & ~(store & dmem_gnt_i)) | (WAIT_RSP & ~dmem_rvalid_i); low otherwise.
REQ-014 SHALL give zero stall for a store granted in its first cycle; a load takes at least 2 cycles (grant cycle plus rvalid cycle).
REQ-015 SHALL make dmem_addr_o = {alu_result_i[31:2],2'b00} and dmem_we_o = memory_write_i.
REQ-016 SHALL form stores from funct3: SB (000) sets be=0001<<a[1:0] with the byte replicated x4; SH (001) sets be=0011<<{a[1],0} with the half replicated x2; SW (010) sets be=1111.
REQ-017 SHALL drive dmem_be_o=1111 for loads.
REQ-018 SHALL extract load data from dmem_rdata_i at the address offset: LB 000 sign-extends, LH 001 sign-extends, LW 010, LBU 100 and LHU 101 zero-extend.
REQ-019 SHALL update the memory-to-writeback register every cycle and load a bubble (reg_write=0, others unchanged) whenever stall_o=1.
REQ-020 SHALL, when stall_o=0, capture the inputs plus read_data (extended load data in the rvalid cycle, else 0).

Reset
REQ-021 SHALL, on rst_n_i low, set the FSM to IDLE, clear every memory-to-writeback register to 0 and drive all outputs to 0 (dmem_req_o=0, stall_o=0).
REQ-022 SHALL discard any in-flight access when reset is asserted mid-operation, ignoring a late dmem_rvalid_i after release.

Configuration
REQ-023 SHALL, with RV32_MEM_MISALIGN_EXC_EN defined, raise misaligned_o (comb) for an access whose LH/LHU/SH has a[0]=1 or whose LW/SW has a[1:0]!=0; that access issues no request, does not stall, and passes reg_write=0.
REQ-024 SHALL, without RV32_MEM_MISALIGN_EXC_EN, omit misaligned_o, treat half accesses as using a[1] only and word accesses as ignoring a[1:0], and never block an access.

Verification
REQ-025 SHALL cover: SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> addr 0x100, be 1111, wdata 0xDEADBEEF, stall_o 0.
REQ-026 SHALL cover: SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
REQ-027 SHALL cover: LB addr 0x102, gnt cycle 0, rvalid cycle 3 with rdata 0x00800000 -> stall_o high cycles 0-2, read_data_o 0xFFFFFF80, reg_write_o 1 from cycle 4.
REQ-028 SHALL cover: LHU addr 0x102, rdata 0xBEEF1234 -> read_data_o 0x0000BEEF.
REQ-029 SHALL cover: load with gnt low for 2 cycles -> req held with stable addr, bubbles (reg_write_o 0) emitted, no duplicate request.
REQ-030 SHALL cover: reset in WAIT_RSP, then rvalid -> FSM stays IDLE, all outputs 0; with the macro, LW at 0x102 -> misaligned_o 1, dmem_req_o 0.
